neander_prog_loader: RTL and testbench
======================================

// Module: neander_prog_loader
// PURPOSE
//  Boot-time program loader in front of the Neander core. Accepts a framed byte
//  stream on a valid/ready port and writes the payload into the core's memory.
//  Holds the core in reset until the payload is written and its checksum passes.
//  On success it releases the core; it then owns no memory cycles until reset_geral.
// PARAMETERS
//  DATA_WIDTH  8      memory word / stream byte width
//  ADDR_WIDTH  8      memory address width (256-word space)
//  MAGIC       8'h4E  frame start byte ('N')
// PORTS
//  clk_geral      in   1           single clock, all logic on rising edge
//  reset_geral    in   1           synchronous, active-high
//  byte_in        in   DATA_WIDTH  stream byte
//  byte_valid     in   1           byte_in valid
//  byte_ready     out  1           loader can accept byte; transfer = valid & ready
//  mem_we         out  1           memory write strobe (one cycle per data byte)
//  mem_addr       out  ADDR_WIDTH  write address
//  mem_data       out  DATA_WIDTH  write data
//  cpu_reset_out  out  1           drives the core's reset_geral; 1 = core held
//  load_done      out  1           frame written, checksum OK (sticky)
//  load_error     out  1           checksum mismatch (sticky)
// BEHAVIOUR
//  Reset: state=IDLE; mem_we=0, mem_addr=0, mem_data=0, cpu_reset_out=1,
//   load_done=0, load_error=0, sum=0, count=0. Reset mid-frame aborts the frame;
//   words already written stay in memory.
//  Frame: MAGIC, START_ADDR, LEN, LEN data bytes, CSUM. LEN=0 means 256 bytes.
//  FSM (advances only on a transfer):
//   IDLE : byte==MAGIC -> ADDR; any other byte is dropped, stay IDLE.
//   ADDR : ptr<=byte -> LEN.
//   LEN  : count<=(byte==0 ? 256 : byte), sum<=0 -> DATA.
//   DATA : write byte at ptr; ptr<=ptr+1 mod 2^ADDR_WIDTH (0xFF wraps to 0x00);
//          sum<=sum+byte mod 2^DATA_WIDTH; count-1; last byte -> CSUM.
//   CSUM : byte==sum -> RUN, else -> ERR.
//   RUN  : cpu_reset_out=0, load_done=1, byte_ready=0; terminal until reset_geral.
//   ERR  : cpu_reset_out=1, load_error=1, byte_ready=0; terminal until reset_geral.
//  byte_ready = 1 in IDLE/ADDR/LEN/DATA/CSUM, combinational from state only
//   (no dependence on byte_valid). Full throughput: 1 byte/cycle.
//  Write timing: mem_we, mem_addr, mem_data are registered; the data byte accepted
//   in cycle t is written with mem_we=1 in cycle t+1. Back-to-back bytes give
//   back-to-back strobes. mem_we is never 1 outside the cycle after a DATA transfer.
//  cpu_reset_out: registered; it falls in the cycle after the CSUM transfer that
//   enters RUN, i.e. after the last mem_we strobe has completed.
//  Gaps (byte_valid=0) in any state: state, sum, count and ptr hold.
//  A MAGIC value inside ADDR/LEN/DATA/CSUM is ordinary data (no resync).
//  load_done and load_error are never both 1.
// STRUCTURE
//  Shared package neander_pkg: loader state enum (IDLE,ADDR,LEN,DATA,CSUM,RUN,ERR),
//   LOADER_MAGIC constant, DATA_WIDTH/ADDR_WIDTH defaults shared with the core.
//  count is ADDR_WIDTH+1 bits wide, so that 256 fits.
//  One sub-module, loader_checksum: clear/enable mod-2^N accumulator holding sum.
//  At top level, cpu_reset_out is ORed with reset_geral before it reaches the core;
//   mem_* are muxed with the core's memory port by cpu_reset_out.
// TESTING
//  1. Stream 4E,10,03,AA,BB,CC,31, no gaps -> mem[10..12]=AA,BB,CC, three consecutive
//     mem_we pulses; cpu_reset_out falls 1 cycle after the CSUM transfer; load_done=1.
//  2. Same frame with CSUM=32 -> no further state change after CSUM, load_error=1,
//     cpu_reset_out stays 1, byte_ready=0.
//  3. Garbage 00,FF,4D then a valid frame -> garbage produces no mem_we; the frame
//     loads correctly.
//  4. START=FE, LEN=03, data 01,02,03, CSUM=06 -> writes at FE,FF,00 (address wrap).
//  5. LEN=00 with 256 bytes of 01, CSUM=00 -> exactly 256 mem_we pulses; load_done=1.
//  6. reset_geral asserted after 2 of 3 data bytes, then a full new frame -> outputs
//     return to reset values, new frame loads, byte_valid gaps keep state.

Source files
------------

// File: rtl/neander_pkg.sv
// Shared definitions for the Neander core and its boot-time program loader.
//   NEANDER_DATA_WIDTH / NEANDER_ADDR_WIDTH : memory word and address widths
//                                             used by the core and the loader
//   LOADER_MAGIC                            : frame start byte ('N')
//   loader_state_e                          : program loader FSM states
package neander_pkg;

  localparam int NEANDER_DATA_WIDTH = 8;
  localparam int NEANDER_ADDR_WIDTH = 8;

  localparam logic [7:0] LOADER_MAGIC = 8'h4E;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_RUN  = 3'd5,
    ST_ERR  = 3'd6
  } loader_state_e;

endpackage

// File: rtl/loader_checksum.sv
// Modular (mod 2^WIDTH) byte accumulator for the program loader checksum.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears sum
//   clear : synchronous clear, clears sum (takes priority over en)
//   en    : add din into sum this cycle
//   din   : value to accumulate
//   sum   : running sum, wraps modulo 2^WIDTH
module loader_checksum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/neander_prog_loader.sv
// Boot-time program loader for the Neander core.
// Receives a frame  MAGIC, START_ADDR, LEN, LEN data bytes, CSUM  on a byte
// stream and writes the payload into the core's memory. The core is held in
// reset (cpu_reset_out=1) until the whole payload is written and the checksum
// matches; then the core is released and the loader stays idle (no memory
// cycles) until reset_geral. LEN=0 means 256 data bytes.
// In the system top, cpu_reset_out is ORed with reset_geral before reaching
// the core, and mem_* are muxed with the core's memory port by cpu_reset_out.
//
// Ports:
//   clk_geral     : clock, all logic on the rising edge
//   reset_geral   : synchronous active-high reset; aborts any frame in flight
//   byte_in       : stream byte
//   byte_valid    : byte_in is valid
//   byte_ready    : loader can accept a byte
//   mem_we        : memory write strobe, one cycle per data byte
//   mem_addr      : memory write address
//   mem_data      : memory write data
//   cpu_reset_out : core reset request, 1 = core held in reset
//   load_done     : frame written and checksum OK (sticky until reset)
//   load_error    : checksum mismatch (sticky until reset)
//   dbg_state     : current loader FSM state
//
// Handshake: a byte is transferred on a rising edge where byte_valid and
// byte_ready are both 1. byte_ready depends on the FSM state only, never on
// byte_valid, and the source must hold byte_in stable while byte_valid=1 and
// byte_ready=0. One byte per cycle is accepted at full rate.
module neander_prog_loader
  import neander_pkg::*;
#(
  parameter int                    DATA_WIDTH = NEANDER_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = NEANDER_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] MAGIC      = DATA_WIDTH'(LOADER_MAGIC)
) (
  input  logic                  clk_geral,
  input  logic                  reset_geral,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_reset_out,
  output logic                  load_done,
  output logic                  load_error,
  output loader_state_e         dbg_state
);

  // count needs one extra bit so that a full 2^ADDR_WIDTH payload fits.
  localparam int CNT_W = ADDR_WIDTH + 1;

  loader_state_e         state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] sum;
  logic                  xfer;

  always_comb begin
    byte_ready = 1'b0;
    case (state)
      ST_IDLE, ST_ADDR, ST_LEN, ST_DATA, ST_CSUM: byte_ready = 1'b1;
      default:                                    byte_ready = 1'b0;
    endcase
  end

  assign xfer      = byte_valid & byte_ready;
  assign dbg_state = state;

  // Sum restarts when LEN is taken, so bytes of an earlier aborted or
  // rejected frame never leak into the next checksum.
  loader_checksum #(
    .WIDTH(DATA_WIDTH)
  ) u_checksum (
    .clk  (clk_geral),
    .rst  (reset_geral),
    .clear(xfer && (state == ST_LEN)),
    .en   (xfer && (state == ST_DATA)),
    .din  (byte_in),
    .sum  (sum)
  );

  always_ff @(posedge clk_geral) begin
    if (reset_geral) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      count         <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      cpu_reset_out <= 1'b1;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      // Strobe is a single cycle; address/data hold their last value.
      mem_we <= 1'b0;
      if (xfer) begin
        case (state)
          ST_IDLE: begin
            if (byte_in == MAGIC) state <= ST_ADDR;
          end
          ST_ADDR: begin
            ptr   <= ADDR_WIDTH'(byte_in);
            state <= ST_LEN;
          end
          ST_LEN: begin
            if (byte_in == '0) count <= CNT_W'(1) << ADDR_WIDTH;
            else               count <= CNT_W'(byte_in);
            state <= ST_DATA;
          end
          ST_DATA: begin
            mem_we   <= 1'b1;
            mem_addr <= ptr;
            mem_data <= byte_in;
            ptr      <= ptr + ADDR_WIDTH'(1);
            count    <= count - CNT_W'(1);
            if (count == CNT_W'(1)) state <= ST_CSUM;
          end
          ST_CSUM: begin
            // sum already includes the last data byte at this point.
            if (byte_in == sum) begin
              state         <= ST_RUN;
              cpu_reset_out <= 1'b0;
              load_done     <= 1'b1;
            end else begin
              state      <= ST_ERR;
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neander_prog_loader.sv
module tb_neander_prog_loader;
  import neander_pkg::*;

  // ---------------- clock / reset ----------------
  logic          clk_geral = 1'b0;
  logic          reset_geral = 1'b1;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          mem_we;
  logic [7:0]    mem_addr;
  logic [7:0]    mem_data;
  logic          cpu_reset_out;
  logic          load_done;
  logic          load_error;
  loader_state_e dbg_state;

  always #5 clk_geral = ~clk_geral;

  neander_prog_loader dut (
    .clk_geral    (clk_geral),
    .reset_geral  (reset_geral),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .cpu_reset_out(cpu_reset_out),
    .load_done    (load_done),
    .load_error   (load_error),
    .dbg_state    (dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];   // expected {addr,data} writes
  logic [15:0] wr_q[$];    // observed {addr,data} writes
  logic [7:0]  tx_q[$];    // bytes of the frame being sent
  bit          exp_done;
  bit          exp_err;

  always @(negedge clk_geral) begin
    if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_data});
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clk_geral);
      @(negedge clk_geral);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && k < 16) begin
      @(posedge clk_geral);
      @(negedge clk_geral);
      k++;
    end
    if (k == 16) check("send_ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk_geral);
    @(negedge clk_geral);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_pct);
    foreach (tx_q[i]) begin
      if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      send_byte(tx_q[i]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_outs"},
          {23'd0, byte_ready, mem_we, cpu_reset_out, load_done, load_error, 4'd0},
          {23'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
    check({tag, "_addr_data"}, {16'd0, mem_addr, mem_data}, 32'd0);
  endtask

  task automatic do_reset(input bit check_vals, input string tag);
    reset_geral = 1'b1;
    byte_valid  = 1'b0;
    byte_in     = 8'h00;
    repeat (2) begin
      @(posedge clk_geral);
      @(negedge clk_geral);
    end
    if (check_vals) check_reset_values(tag);
    reset_geral = 1'b0;
    wr_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Works on the raw byte list: skip to the first MAGIC, then read header,
  // payload and checksum straight from the list.
  task automatic model_frame();
    int         i = 0;
    int         n;
    logic [7:0] a;
    logic [7:0] s = 8'h00;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    while (i < tx_q.size() && tx_q[i] != LOADER_MAGIC) i++;
    a = tx_q[i+1];
    n = (tx_q[i+2] == 8'h00) ? 256 : int'(tx_q[i+2]);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back({8'(int'(a) + j), tx_q[i+3+j]});
      s = s + tx_q[i+3+j];
    end
    if (tx_q[i+3+n] == s) exp_done = 1'b1;
    else                  exp_err  = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    int n;
    idle(2);
    check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_write%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
    check({tag, "_status"},
          {28'd0, load_done, load_error, cpu_reset_out, byte_ready},
          {28'd0, exp_done, exp_err, !exp_done, !(exp_done || exp_err)});
    check({tag, "_not_both"}, {31'd0, load_done & load_error}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       rdy;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       cpu;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Frame 4E,10,03,AA,BB,CC,31 with no gaps; outputs after each edge.
    tbl[0] = '{1'b1, 8'h4E, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'hAA, 1'b1, 1'b1, 8'h10, 8'hAA, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'hBB, 1'b1, 1'b1, 8'h11, 8'hBB, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'hCC, 1'b1, 1'b1, 8'h12, 8'hCC, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h31, 1'b0, 1'b0, 8'h12, 8'hCC, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 8'hCC, 1'b0, 1'b1, 1'b0};

    do_reset(1'b1, "reset0");

    // Test 1: table-driven nominal frame
    foreach (tbl[i]) begin
      byte_valid = tbl[i].v;
      byte_in    = tbl[i].b;
      @(posedge clk_geral);
      @(negedge clk_geral);
      check($sformatf("t1_vec%0d", i),
            {9'd0, byte_ready, mem_we, mem_addr, mem_data, cpu_reset_out, load_done, load_error, 2'd0},
            {9'd0, tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].cpu, tbl[i].done, tbl[i].err, 2'd0});
    end
    byte_valid = 1'b0;
    check("t1_state_run", 32'(dbg_state), 32'(ST_RUN));

    // Test 2: bad checksum, then further bytes must be refused
    do_reset(1'b0, "");
    tx_q = '{8'h4E, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h32};
    model_frame();
    send_frame(0);
    check_frame("t2");
    byte_in    = 8'h4E;
    byte_valid = 1'b1;
    repeat (3) begin
      @(posedge clk_geral);
      @(negedge clk_geral);
      check("t2_err_no_we", {31'd0, mem_we}, 32'd0);
    end
    byte_valid = 1'b0;
    check("t2_state_err", 32'(dbg_state), 32'(ST_ERR));

    // Test 3: garbage before the frame; MAGIC inside payload is plain data
    do_reset(1'b0, "");
    tx_q = '{8'h00, 8'hFF, 8'h4D, 8'h4E, 8'h40, 8'h02, 8'h4E, 8'h01, 8'h4F};
    model_frame();
    send_frame(0);
    check_frame("t3");

    // Test 4: address wrap
    do_reset(1'b0, "");
    tx_q = '{8'h4E, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    model_frame();
    send_frame(0);
    check_frame("t4");

    // Test 5: LEN=0 means 256 bytes
    do_reset(1'b0, "");
    tx_q.delete();
    tx_q.push_back(8'h4E);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    repeat (256) tx_q.push_back(8'h01);
    tx_q.push_back(8'h00);
    model_frame();
    send_frame(0);
    check_frame("t5");

    // Test 6: reset mid-frame, then a new frame with gaps
    do_reset(1'b0, "");
    tx_q = '{8'h4E, 8'h20, 8'h03, 8'h11, 8'h22};
    send_frame(0);
    do_reset(1'b1, "t6_abort");
    send_byte(8'h4E);
    send_byte(8'h20);
    repeat (3) begin
      idle(1);
      check("t6_gap_state", 32'(dbg_state), 32'(ST_LEN));
      check("t6_gap_outs", {30'd0, byte_ready, mem_we}, {30'd0, 1'b1, 1'b0});
    end
    send_byte(8'h02);
    send_byte(8'h55);
    idle(2);
    check("t6_gap_data_state", 32'(dbg_state), 32'(ST_DATA));
    send_byte(8'h66);
    idle(1);
    send_byte(8'hBB);
    tx_q = '{8'h4E, 8'h20, 8'h02, 8'h55, 8'h66, 8'hBB};
    model_frame();
    check_frame("t6");

    // Randomized frames against the reference model
    for (int f = 0; f < 20; f++) begin
      int         len;
      logic [7:0] s;
      logic [7:0] g;
      do_reset(1'b0, "");
      tx_q.delete();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom_range(0, 255));
        tx_q.push_back((g == LOADER_MAGIC) ? 8'h00 : g);
      end
      len = $urandom_range(1, 24);
      tx_q.push_back(LOADER_MAGIC);
      tx_q.push_back(8'($urandom_range(0, 255)));
      tx_q.push_back(8'(len));
      s = 8'h00;
      for (int j = 0; j < len; j++) begin
        g = 8'($urandom_range(0, 255));
        tx_q.push_back(g);
        s = s + g;
      end
      tx_q.push_back(($urandom_range(0, 1) == 1) ? s : s + 8'($urandom_range(1, 255)));
      model_frame();
      send_frame(25);
      check_frame($sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
